// File: rtl/add3_accum.sv
// -----------------------------------------------------------------------------
// add3_accum
//
// Clocked accumulator that sits downstream of the 3-bit ripple adder. It
// accepts NUM_OPS unsigned operands over a valid/ready handshake, folds each
// into a WIDTH-bit running sum (modular, or saturating when ACCUM_SAT_EN is
// defined) and keeps a sticky flag of any carry-out. The finished result is
// then offered downstream over a second valid/ready handshake.
//
// Optional build macro:
//   ACCUM_SAT_EN  - when defined, a carry-out clamps the sum to all-ones
//                   instead of wrapping.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of the accumulation / pending result
//   in_valid   operand valid
//   in_ready   block can accept an operand
//   in_data    operand (WIDTH bits, unsigned)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum
//   out_carry  sticky carry-out flag for this result
//   out_count  operands accepted so far in the current result
// -----------------------------------------------------------------------------
module add3_accum #(
  parameter int WIDTH   = 3,
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Low during reset and for the first edge after it, so in_ready only rises
  // one clock after rst_n deasserts.
  logic             live;

  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             last_op;
  logic             result_done;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_next;

  // Handshake flags decode straight from registers: no in_* -> out_* path.
  assign in_ready  = live && (state == ACC);
  assign out_valid = (state == HOLD);

  assign out_sum   = acc;
  assign out_carry = carry;
  assign out_count = count;

  assign accept      = in_valid && in_ready;
  assign last_op     = (count == CNT_W'(NUM_OPS - 1));
  // A pending result leaves HOLD on either a downstream accept or a clear.
  assign result_done = (state == HOLD) && (out_ready || clr);

  // Top bit of the widened add is the adder carry-out.
  assign sum_full = {1'b0, acc} + {1'b0, in_data};

`ifdef ACCUM_SAT_EN
  assign sum_next = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
  assign sum_next = sum_full[WIDTH-1:0];
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch
    // would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ACC:     if (accept && !clr && last_op) state_nxt = HOLD;
      HOLD:    if (out_ready || clr)          state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state <= ACC;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Accumulator datapath. clr wins over a simultaneous accept; that operand
  // is dropped even though its handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if ((state == ACC && clr) || result_done) begin
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (accept) begin
      acc   <= sum_next;
      carry <= carry | sum_full[WIDTH];
      count <= count + CNT_W'(1);
    end
  end

endmodule
